// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
//   Multi-cycle shift sequencer that drives an external one-position
//   combinational shifter. The operand is loaded on start, then stepped
//   through the shifter once per cycle, amt times. The final value appears
//   on result together with a one-cycle done pulse.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   request; only honoured while idle
//   A_in    operand to shift
//   op      00 ROR, 01 LSR, 10 ROL, 11 LSL (passed to the shifter unchanged)
//   amt     number of one-position steps, 0..2**AMT_W-1
//   sh_a    to shifter operand input (the work register)
//   sh_s    to shifter select input (the latched op)
//   sh_out  from shifter output, combinational in sh_a/sh_s
//   busy    high whenever the sequencer is not idle
//   done    one-cycle pulse, coincident with result updating
//   result  final shifted value, held until the next completion
// -----------------------------------------------------------------------------
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] sh_a,
  output logic [1:0]       sh_s,
  input  logic [WIDTH-1:0] sh_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  // Next-state and datapath decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = A_in;
          op_d    = op;
          cnt_d   = amt;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = sh_out;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // done and result are registered on entry to DONE; result takes the value
    // the work register is about to hold, so amt==0 yields A_in directly.
    done_d   = (state_d == DONE);
    result_d = (state_d == DONE) ? work_d : result_q;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign sh_a   = work_q;
  assign sh_s   = op_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
